fetch_stage: RTL and testbench

- Front-end stage of cpu_top, directly upstream of decode.
- Owns the PC and issues in-order word requests to instruction memory.
- Buffers returned instructions in a small fetch queue and presents {pc, instr} to decode over a valid/ready handshake.
- Handles backend redirects by flushing the queue and discarding stale in-flight responses.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_queue.sv | 60 ++++++
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths/reset vector and the
// packet handed from fetch to decode.
package cpu_pkg;

    localparam int              CPU_XLEN     = 32;
    localparam logic [CPU_XLEN-1:0] CPU_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [CPU_XLEN-1:0] pc;
        logic [CPU_XLEN-1:0] instr;
    } fetch_pkt_t;

    // Instruction fetch is word granular; low address bits are dropped.
    function automatic logic [CPU_XLEN-1:0] word_align(input logic [CPU_XLEN-1:0] addr);
        return {addr[CPU_XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch packets. Pointers wrap naturally (DEPTH is
// a power of two); an explicit count distinguishes full from empty.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_pkt_t             push_pkt,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_pkt_t             head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);

    fetch_pkt_t     mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           push_en;
    logic           pop_en;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH[PW:0]);
    assign pop_en  = pop && !empty;
    // A push into a full queue is only legal when the head leaves this cycle.
    assign push_en = push && (!full || pop_en);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push_en && !flush) mem[wr_ptr] <= push_pkt;
    end

endmodule

// File: rtl/fetch_stage.sv
// Front-end fetch: owns the PC, issues in-order word requests to imem,
// buffers responses and presents {pc, instr} to decode.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int              XLEN     = CPU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = CPU_RESET_PC,
    parameter int              FQ_DEPTH = 4,
    parameter int              MAX_OUT  = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_instr
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rsp_pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   drop_cnt;
    logic [OW-1:0]   rsp_dec;
    logic [OW-1:0]   req_inc;
    logic [XLEN-1:0] target_pc;

    logic            req_fire;
    logic            rsp_keep;
    logic            fq_pop;
    int              credit_used;

    fetch_pkt_t      push_pkt;
    fetch_pkt_t      fq_head;
    logic [CW-1:0]   fq_count;
    logic            fq_full;
    logic            fq_empty;

    // Every issued, not-yet-dropped request has a reserved queue slot.
    always_comb begin
        credit_used = int'(fq_count) + int'(outstanding) - int'(drop_cnt);
    end

    assign imem_req_valid = !rst && !redirect_valid
                            && (int'(outstanding) < MAX_OUT)
                            && (credit_used < FQ_DEPTH);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_keep  = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign rsp_dec   = {{(OW-1){1'b0}}, imem_rsp_valid};
    assign req_inc   = {{(OW-1){1'b0}}, req_fire};
    assign target_pc = word_align(redirect_pc);

    assign push_pkt.pc    = rsp_pc;
    assign push_pkt.instr = imem_rsp_data;

    assign dec_valid = !fq_empty && !redirect_valid;
    assign fq_pop    = dec_valid && dec_ready;
    assign dec_pc    = fq_empty ? '0 : fq_head.pc;
    assign dec_instr = fq_empty ? '0 : fq_head.instr;

    // Redirect takes priority: anything still in flight becomes stale,
    // including a response landing in the redirect cycle itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            pc          <= target_pc;
            rsp_pc      <= target_pc;
            outstanding <= outstanding - rsp_dec;
            drop_cnt    <= outstanding - rsp_dec;
        end else begin
            if (req_fire) pc     <= pc + XLEN'(4);
            if (rsp_keep) rsp_pc <= rsp_pc + XLEN'(4);
            outstanding <= outstanding + req_inc - rsp_dec;
            if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        end
    end

    fetch_queue #(
        .DEPTH(FQ_DEPTH)
    ) u_fq (
        .clk      (clk),
        .rst      (rst),
        .push     (rsp_keep),
        .push_pkt (push_pkt),
        .pop      (fq_pop),
        .flush    (redirect_valid),
        .head     (fq_head),
        .count    (fq_count),
        .full     (fq_full),
        .empty    (fq_empty)
    );

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(rsp_keep && fq_full && !fq_pop))
                else $error("fetch queue overflow at rsp_pc=%h", rsp_pc);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order imem model and a
// scoreboard of expected decode packets.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;

    always #5 clk = ~clk;

    fetch_stage #(
        .XLEN(32), .RESET_PC(32'h0000_0000), .FQ_DEPTH(4), .MAX_OUT(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr)
    );

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } pend_t;

    pend_t       pend[$];
    fetch_pkt_t  exp_q[$];
    int          nchecks = 0;
    int          nerr    = 0;
    int          cyc     = 0;
    int          lat     = 1;
    int          req_fires;
    int          dec_fires;
    logic [31:0] exp_fetch_pc;
    logic [31:0] exp_dec_pc;
    logic [31:0] first_req_addr;
    logic [31:0] first_dec_pc;
    logic [31:0] held_addr;
    int          req_snap;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp)
            else begin
                nerr++;
                $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
            end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        nchecks++;
        assert (obs === exp)
            else begin
                nerr++;
                $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
            end
    endtask

    task automatic bench_reset_state();
        pend.delete();
        exp_q.delete();
        exp_fetch_pc = 32'h0;
        exp_dec_pc   = 32'h0;
    endtask

    // One clock cycle: called at a negedge with this cycle's inputs set.
    task automatic step();
        logic        rsp_now, rd, rf, df;
        logic [31:0] ra, rpc;
        int          kept;
        pend_t       h;
        fetch_pkt_t  e;

        rsp_now = (pend.size() > 0) && (pend[0].due <= cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? instr_of(pend[0].addr) : $urandom;
        #4;
        rd  = redirect_valid;
        rpc = redirect_pc;
        kept = 0;
        foreach (pend[i]) if (!pend[i].stale) kept++;
        check1("dec_valid", dec_valid, (exp_q.size() > 0) && !rd);
        check1("imem_req_valid", imem_req_valid,
               !rd && (pend.size() < 2) && (exp_q.size() + kept < 4));
        rf = imem_req_valid && imem_req_ready;
        df = dec_valid && dec_ready;
        ra = imem_req_addr;
        if (rf) begin
            check("imem_req_addr", ra, exp_fetch_pc);
            if (req_fires == 0) first_req_addr = ra;
            req_fires++;
        end
        if (df) begin
            if (exp_q.size() == 0) begin
                check("dec_unexpected", dec_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("dec_pc", dec_pc, e.pc);
                check("dec_instr", dec_instr, e.instr);
                check("dec_pc_seq", dec_pc, exp_dec_pc);
                exp_dec_pc += 32'd4;
            end
            if (dec_fires == 0) first_dec_pc = dec_pc;
            dec_fires++;
        end
        @(posedge clk);
        if (rsp_now) begin
            h = pend.pop_front();
            if (!h.stale && !rd) exp_q.push_back('{pc: h.addr, instr: instr_of(h.addr)});
        end
        if (rd) begin
            exp_q.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            exp_fetch_pc = {rpc[31:2], 2'b00};
            exp_dec_pc   = exp_fetch_pc;
        end
        if (rf) begin
            pend.push_back('{addr: ra, stale: 1'b0, due: cyc + lat});
            exp_fetch_pc += 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until_dec(input int budget, input string tag);
        int n;
        n = 0;
        while (dec_fires == 0 && n < budget) begin
            step();
            n++;
        end
        if (dec_fires == 0) check(tag, 32'(dec_fires), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b1;
        req_fires      = 0;
        dec_fires      = 0;
        first_req_addr = 32'hDEAD_BEEF;
        first_dec_pc   = 32'hDEAD_BEEF;
        bench_reset_state();

        // Reset held for five cycles
        @(negedge clk);
        repeat (5) begin
            check1("rst_dec_valid", dec_valid, 1'b0);
            check1("rst_req_valid", imem_req_valid, 1'b0);
            check("rst_dec_pc", dec_pc, 32'h0);
            check("rst_dec_instr", dec_instr, 32'h0);
            @(negedge clk);
        end
        rst = 1'b0;

        // Streaming from RESET_PC, no gaps in steady state
        step();
        check("first_req_count", 32'(req_fires), 32'd1);
        check("first_req_addr", first_req_addr, 32'h0);
        repeat (4) step();
        check("first_dec_pc", first_dec_pc, 32'h0);
        dec_fires = 0;
        repeat (10) step();
        check("steady_no_gaps", 32'(dec_fires), 32'd10);

        // Decode backpressure fills the queue and stops requests
        dec_ready = 1'b0;
        repeat (8) step();
        check("bp_queue_full", 32'(exp_q.size()), 32'd4);
        check1("bp_req_stalled", imem_req_valid, 1'b0);
        check1("bp_dec_valid", dec_valid, 1'b1);
        dec_ready = 1'b1;
        dec_fires = 0;
        repeat (12) step();
        check1("bp_resume", dec_fires >= 8, 1'b1);

        // imem not ready for three cycles
        held_addr = imem_req_addr;
        req_snap  = req_fires;
        imem_req_ready = 1'b0;
        repeat (3) begin
            step();
            check("stall_addr_held", imem_req_addr, held_addr);
            check1("stall_req_valid", imem_req_valid, 1'b1);
        end
        check("stall_no_req", 32'(req_fires), 32'(req_snap));
        imem_req_ready = 1'b1;
        repeat (4) step();

        // Redirect with two requests outstanding and a non-empty queue
        lat = 2;
        repeat (6) step();
        dec_ready = 1'b0;
        begin
            int n;
            n = 0;
            while (!(pend.size() == 2 && exp_q.size() >= 1) && n < 20) begin
                step();
                n++;
            end
            check1("redir_setup", pend.size() == 2 && exp_q.size() >= 1, 1'b1);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        req_fires = 0;
        dec_fires = 0;
        step();
        redirect_valid = 1'b0;
        dec_ready      = 1'b1;
        run_until_dec(20, "redir_timeout");
        check("redir_first_req", first_req_addr, 32'h0000_0100);
        check("redir_first_dec", first_dec_pc, 32'h0000_0100);
        repeat (6) step();

        // Redirect coincident with a response, then back-to-back redirect
        begin
            int n;
            n = 0;
            while (!(pend.size() > 0 && pend[0].due <= cyc) && n < 10) begin
                step();
                n++;
            end
            check1("coinc_setup", pend.size() > 0 && pend[0].due <= cyc, 1'b1);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_pc    = 32'h0000_0300;
        req_fires = 0;
        dec_fires = 0;
        step();
        redirect_valid = 1'b0;
        run_until_dec(20, "b2b_timeout");
        check("b2b_first_req", first_req_addr, 32'h0000_0300);
        check("b2b_first_dec", first_dec_pc, 32'h0000_0300);
        repeat (6) step();

        // PC wraps modulo 2^32
        lat = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFA;
        req_fires = 0;
        dec_fires = 0;
        step();
        redirect_valid = 1'b0;
        run_until_dec(20, "wrap_timeout");
        check("wrap_first_dec", first_dec_pc, 32'hFFFF_FFF8);
        dec_fires = 0;
        repeat (6) step();
        check1("wrap_stream", dec_fires >= 4, 1'b1);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        check1("arst_dec_valid", dec_valid, 1'b0);
        check1("arst_req_valid", imem_req_valid, 1'b0);
        check("arst_dec_pc", dec_pc, 32'h0);
        check("arst_dec_instr", dec_instr, 32'h0);
        bench_reset_state();
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_fires = 0;
        dec_fires = 0;
        run_until_dec(20, "arst_timeout");
        check("arst_first_req", first_req_addr, 32'h0);
        check("arst_first_dec", first_dec_pc, 32'h0);
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
